// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop serialiser
// paced by a 16x oversampling tick. sout is registered and idles high.
module uart_transmitter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck_rising_edge,
    input  logic       tx_data_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       overflow,
    input  logic       overflow_clear,
    output logic       busy,
    output logic       sout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_ACTIVE,
        S_STOP
    } state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    state_t        state_q;
    logic [3:0]    edges_q;
    logic [2:0]    bits_q;
    logic [7:0]    shift_q;
    logic          sout_q;

    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          last_edge;

    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign push      = tx_data_valid && !fifo_full;
    // Pop decision uses the registered count, so a byte pushed into an empty
    // FIFO is only popped on the following cycle.
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign last_edge = sck_rising_edge && (edges_q == 4'd15);

    assign tx_ready  = !fifo_full;
    assign overflow  = overflow_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign sout      = sout_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A dropped write wins over a simultaneous clear.
            if (tx_data_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (overflow_clear) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // sout is loaded with the level of the state being entered, so the line
    // and the state change on the same clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            edges_q <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            sout_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sout_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_mem[rd_ptr_q];
                        edges_q <= '0;
                        bits_q  <= '0;
                        state_q <= S_START;
                        sout_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (sck_rising_edge) begin
                        edges_q <= last_edge ? 4'd0 : edges_q + 4'd1;
                    end
                    if (last_edge) begin
                        state_q <= S_ACTIVE;
                        sout_q  <= shift_q[0];
                    end
                end
                S_ACTIVE: begin
                    if (sck_rising_edge) begin
                        edges_q <= last_edge ? 4'd0 : edges_q + 4'd1;
                    end
                    if (last_edge) begin
                        shift_q <= shift_q >> 1;
                        if (bits_q == 3'd7) begin
                            bits_q  <= '0;
                            state_q <= S_STOP;
                            sout_q  <= 1'b1;
                        end else begin
                            bits_q <= bits_q + 3'd1;
                            sout_q <= shift_q[1];
                        end
                    end
                end
                S_STOP: begin
                    sout_q <= 1'b1;
                    if (sck_rising_edge) begin
                        edges_q <= last_edge ? 4'd0 : edges_q + 4'd1;
                    end
                    if (last_edge) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    sout_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame shape and timing, FIFO overflow,
// mid-frame reset and tick stall, with hand-derived expected line levels.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck_rising_edge = 1'b0;
    logic       tx_data_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       overflow;
    logic       overflow_clear = 1'b0;
    logic       busy;
    logic       sout;

    int vectors_applied = 0;
    int miscompares = 0;
    bit tick_en = 1'b1;

    uart_transmitter #(.FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sck_rising_edge (sck_rising_edge),
        .tx_data_valid   (tx_data_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .overflow        (overflow),
        .overflow_clear  (overflow_clear),
        .busy            (busy),
        .sout            (sout)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks; updated slightly after the falling edge so the
    // main process can gate it cleanly at that edge.
    initial begin
        int phase = 0;
        forever begin
            @(negedge clk);
            #2;
            phase = (phase + 1) % 4;
            sck_rising_edge = tick_en && (phase == 0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        tx_data = b;
        tx_data_valid = 1'b1;
        @(negedge clk);
        tx_data_valid = 1'b0;
    endtask

    // Returns at the falling edge after the next clock edge that carried a tick.
    task automatic wait_tick();
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            if (sck_rising_edge) got = 1'b1;
        end
        @(negedge clk);
        if (!got) chk("tick_timeout", 1'b0, 1'b1);
    endtask

    // mode 0: another frame queued (check 1-clk gap), 1: expect idle after,
    // 2: return at the end of stop without further checks.
    task automatic check_frame(input logic [7:0] b, input int freeze_at, input int mode);
        int n = 0;
        logic lvl;
        logic [9:0] exp_bits;
        exp_bits = {1'b1, b, 1'b0};
        while (sout !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start", sout, 1'b0);
        for (int t = 1; t <= 160; t++) begin
            wait_tick();
            if (t % 16 == 8) chk($sformatf("frame_%02h_bit%0d", b, t / 16), sout, exp_bits[t / 16]);
            if (t == 159) chk("busy_in_stop", busy, 1'b1);
            if (t == freeze_at) begin
                lvl = sout;
                tick_en = 1'b0;
                repeat (100) @(negedge clk);
                chk("freeze_sout", sout, lvl);
                chk("freeze_busy", busy, 1'b1);
                tick_en = 1'b1;
            end
        end
        chk("frame_end_sout", sout, 1'b1);
        if (mode == 0) begin
            chk("gap_busy", busy, 1'b1);
            @(negedge clk);
            chk("gap_next_start", sout, 1'b0);
        end else if (mode == 1) begin
            chk("idle_busy", busy, 1'b0);
        end
        $display("frame %02h checked (%0d vectors so far)", b, vectors_applied);
    endtask

    logic [7:0] ov_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    logic [7:0] basic_bytes [3] = '{8'h00, 8'hFF, 8'h55};
    logic [7:0] b81;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sout", sout, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5 with latency check: sout falls 2 clks after the write cycle.
        wr(8'hA5);
        chk("lat_sout_n1", sout, 1'b1);
        chk("lat_busy_n1", busy, 1'b1);
        @(negedge clk);
        chk("lat_sout_n2", sout, 1'b0);
        check_frame(8'hA5, 0, 1);

        for (int i = 0; i < 3; i++) begin
            wr(basic_bytes[i]);
            check_frame(basic_bytes[i], 0, 1);
        end

        // Overflow: frame held in START with ticks stopped while the FIFO fills.
        tick_en = 1'b0;
        repeat (2) @(negedge clk);
        wr(8'h3C);
        @(negedge clk);
        chk("ov_first_popped", sout, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tx_data = ov_bytes[i];
            tx_data_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("ov_tx_ready_after_%0d", i + 1), tx_ready, (i < 3) ? 1'b1 : 1'b0);
        end
        tx_data_valid = 1'b0;
        chk("ov_flag_set", overflow, 1'b1);
        tx_data = 8'h99;
        tx_data_valid = 1'b1;
        overflow_clear = 1'b1;
        @(negedge clk);
        tx_data_valid = 1'b0;
        chk("ov_clear_with_drop", overflow, 1'b1);
        @(negedge clk);
        overflow_clear = 1'b0;
        chk("ov_cleared", overflow, 1'b0);
        tick_en = 1'b1;
        check_frame(8'h3C, 0, 2);

        // Full FIFO, IDLE pops in the same cycle as a write: write is dropped.
        tx_data = 8'hEE;
        tx_data_valid = 1'b1;
        @(negedge clk);
        tx_data_valid = 1'b0;
        chk("popfull_started", sout, 1'b0);
        chk("popfull_tx_ready", tx_ready, 1'b1);
        chk("popfull_overflow", overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_frame(ov_bytes[i], 0, (i < 3) ? 0 : 1);
        end
        chk("ov_sticky", overflow, 1'b1);

        // Reset in the middle of data bit 3, with another byte queued.
        b81 = 8'h81;
        wr(b81);
        wr(8'h7E);
        chk("rstmid_started", sout, 1'b0);
        for (int t = 1; t <= 72; t++) wait_tick();
        chk("rstmid_bit3", sout, b81[3]);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_sout", sout, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_tx_ready", tx_ready, 1'b1);
        chk("rstmid_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstmid_stays_idle", sout, 1'b1);
        chk("rstmid_fifo_empty", busy, 1'b0);
        wr(8'h5A);
        check_frame(8'h5A, 0, 1);

        // Tick stall just before the bit1 -> bit2 transition of 0xC3.
        wr(8'hC3);
        check_frame(8'hC3, 47, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
